// File: rtl/bus_xfer_arbiter_if.sv
// Bus-transfer arbiter port bundle: requesters drive req/dst (master), the arbiter drives
// the bus controls and completion pulses (slave).
interface bus_xfer_arbiter_if;
  logic [2:0] req;
  logic [1:0] dst0;
  logic [1:0] dst1;
  logic [1:0] dst2;
  logic [1:0] select;
  logic [2:0] read;
  logic [2:0] load;
  logic [2:0] inc;
  logic [2:0] ack;
  logic [2:0] err;
  logic       busy;

  modport master (
    output req, dst0, dst1, dst2,
    input  select, read, load, inc, ack, err, busy
  );

  modport slave (
    input  req, dst0, dst1, dst2,
    output select, read, load, inc, ack, err, busy
  );
endinterface

// File: rtl/bus_xfer_arbiter.sv
// Round-robin owner of the shared AR/DR/PC bus; sequences select -> read -> load -> ack per grant.
// Latency: ack lands HOLD_CYCLES+3 cycles after req is seen in IDLE (+1 INC cycle with BUS_XFER_AUTOINC_EN).
// Backpressure: none; requesters hold req/dst until ack/err, one grant per IDLE visit.
module bus_xfer_arbiter #(
  parameter int HOLD_CYCLES = 1,
  parameter int NREQ        = 3
) (
  input  logic              clk,
  input  logic              rst,
  bus_xfer_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    LOAD,
`ifdef BUS_XFER_AUTOINC_EN
    INC,
`endif
    ACK,
    REJECT
  } state_t;

  localparam logic [1:0] NO_DRV    = 2'b11;
  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

  state_t            state, state_nxt;
  logic [1:0]        src, src_nxt;
  logic [1:0]        dst, dst_nxt;
  logic [1:0]        ptr, ptr_nxt;
  logic [3:0]        hold, hold_nxt;
  logic [2:0]        pick;
  logic [1:0]        win_dst;

  logic [1:0]        select_nxt, select_q;
  logic [NREQ-1:0]   read_nxt, read_q;
  logic [NREQ-1:0]   load_nxt, load_q;
  logic [NREQ-1:0]   inc_nxt, inc_q;
  logic [NREQ-1:0]   ack_nxt, ack_q;
  logic [NREQ-1:0]   err_nxt, err_q;
  logic              busy_nxt, busy_q;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // {valid, index} of the first requester at or after the pointer.
  function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
    logic [1:0] c;
    rr_pick = 3'b000;
    c = p;
    for (int i = 0; i < 3; i++) begin
      if (r[c] && !rr_pick[2]) rr_pick = {1'b1, c};
      c = wrap_inc(c);
    end
  endfunction

  assign pick = rr_pick(ptr, bus.req);

  always_comb begin
    case (pick[1:0])
      2'd0:    win_dst = bus.dst0;
      2'd1:    win_dst = bus.dst1;
      default: win_dst = bus.dst2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      src   <= 2'd0;
      dst   <= 2'd0;
      ptr   <= 2'd0;
      hold  <= 4'd0;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
      dst   <= dst_nxt;
      ptr   <= ptr_nxt;
      hold  <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    dst_nxt   = dst;
    ptr_nxt   = ptr;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          src_nxt = pick[1:0];
          dst_nxt = win_dst;
          if (win_dst == pick[1:0] || win_dst == 2'd3) begin
            state_nxt = REJECT;
          end else begin
            state_nxt = DRIVE;
            hold_nxt  = HOLD_INIT;
          end
        end
      end
      DRIVE: begin
        if (hold == 4'd0) state_nxt = LOAD;
        else              hold_nxt  = hold - 4'd1;
      end
`ifdef BUS_XFER_AUTOINC_EN
      LOAD:    state_nxt = INC;
      INC:     state_nxt = ACK;
`else
      LOAD:    state_nxt = ACK;
`endif
      ACK, REJECT: begin
        ptr_nxt   = wrap_inc(src);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded for the state being entered so the flops line up with it.
    select_nxt = NO_DRV;
    read_nxt   = '0;
    load_nxt   = '0;
    inc_nxt    = '0;
    ack_nxt    = '0;
    err_nxt    = '0;
    busy_nxt   = (state_nxt != IDLE);
    case (state_nxt)
      DRIVE: begin
        select_nxt = src_nxt;
        read_nxt   = onehot(src_nxt);
      end
      LOAD: begin
        select_nxt = src_nxt;
        read_nxt   = onehot(src_nxt);
        load_nxt   = onehot(dst_nxt);
      end
`ifdef BUS_XFER_AUTOINC_EN
      INC:     inc_nxt = onehot(src_nxt);
`endif
      ACK:     ack_nxt = onehot(src_nxt);
      REJECT:  err_nxt = onehot(src_nxt);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      select_q <= NO_DRV;
      read_q   <= '0;
      load_q   <= '0;
      inc_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      select_q <= select_nxt;
      read_q   <= read_nxt;
      load_q   <= load_nxt;
      inc_q    <= inc_nxt;
      ack_q    <= ack_nxt;
      err_q    <= err_nxt;
      busy_q   <= busy_nxt;
    end
  end

  assign bus.select = select_q;
  assign bus.read   = read_q;
  assign bus.load   = load_q;
  assign bus.inc    = inc_q;
  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;

endmodule

// File: doc/bus_xfer_arbiter.md
Name: bus_xfer_arbiter

Overview:
- Arbitrates the shared 16-bit data bus between the three bus-register masters: AR (0), DR (1) and PC (2).
- Sequences each granted register-to-register transfer: drives the bus select, asserts the source read, asserts the destination load, then acknowledges the requester.
- Sits beside the BUS mux and the AR/DR/PC registers, replacing hand-timed testbench control of select/read/load.

Parameters:
- HOLD_CYCLES, 1, cycles the source drives the bus before the destination load (1..15).
- NREQ, 3, number of masters; fixed at 3 (AR, DR, PC).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  3  transfer request per master; bit 0 AR, bit 1 DR, bit 2 PC.
- dst0  input  2  destination code for the AR request (0 AR, 1 DR, 2 PC).
- dst1  input  2  destination code for the DR request.
- dst2  input  2  destination code for the PC request.
- select  output  2  bus mux select, equal to the source code; 2'b11 means no driver.
- read  output  3  one-hot source read enable.
- load  output  3  one-hot destination load enable.
- inc  output  3  one-hot source increment (used only with the optional feature; otherwise 0).
- ack  output  3  one-cycle completion pulse to the requester.
- err  output  3  one-cycle reject pulse to the requester.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, select=2'b11, read=load=inc=ack=err=0, busy=0, priority pointer=0 (AR highest). A transfer in flight is abandoned with no ack.
- All outputs are registered, decoded from state and the latched grant.
- IDLE:
  - If req is nonzero, pick a winner round-robin starting at the pointer. Latch src=winner and dst=dst<winner>.
  - If dst==src or dst==3: go to REJECT. Otherwise go to DRIVE with hold counter=HOLD_CYCLES-1.
  - Only one grant is made per IDLE visit.
- DRIVE: select=src, read[src]=1. Stay until the hold counter reaches 0 (decrement each cycle), then go to LOAD.
- LOAD: exactly 1 cycle. select=src, read[src]=1, load[dst]=1. Next state is ACK (or INC with the optional feature).
- ACK: exactly 1 cycle. ack[src]=1, select=2'b11, read=0, load=0. Pointer becomes (src+1) mod 3. Next state IDLE.
- REJECT: exactly 1 cycle. err[src]=1, select=2'b11, no read/load. Pointer becomes (src+1) mod 3. Next state IDLE.
- Latency from req rising (observed in IDLE) to ack: HOLD_CYCLES+3 cycles. Minimum IDLE gap between back-to-back transfers: 1 cycle.
- Requester handshake:
  - Hold req and dst stable until ack or err.
  - dst is sampled only in IDLE; later changes are ignored.
  - Deasserting req mid-transfer does not abort; ack is still issued.
  - req still high in the cycle after ack starts a new arbitration (a new transfer).
- Simultaneous requests: strict round-robin, so no master is starved. With all three continuously requesting, the grant order from reset is AR, DR, PC, AR, ...
- select never equals a source code unless read of that same source is high (single bus driver guaranteed).
- load and read are never asserted for the same register in the same cycle.

Optional Feature:
- BUS_XFER_AUTOINC_EN defined:
  - After LOAD, enter INC for 1 cycle: inc[src]=1, select=2'b11, read=load=0. Then ACK.
  - Latency becomes HOLD_CYCLES+4.
  - Supports streaming PC->AR with PC post-increment.
- Not defined: INC state absent, inc held at 0, latency HOLD_CYCLES+3.

Test Plan:
- Reset mid-DRIVE (HOLD_CYCLES=4, rst pulsed in the 2nd DRIVE cycle): next edge shows select=2'b11, busy=0, ack never pulses, pointer=0.
- Single transfer: req=3'b001, dst0=2'd1, HOLD_CYCLES=1 -> DRIVE cycle with select=2'b00, read=3'b001; then load=3'b010 with select=2'b00; then ack=3'b001, 4 cycles after req is sampled.
- Contention: req=3'b111 held, dst0=1, dst1=2, dst2=0 -> acks in order 001, 010, 100, 001; select sequence 00, 01, 10, 00.
- Reject: req=3'b100, dst2=2'd2 -> err=3'b100 one cycle later, load stays 0, pointer then favours AR.
- HOLD_CYCLES=3, req=3'b010, dst1=0 -> read[1] high for 4 cycles, load[0] high in the 4th only, ack follows. With BUS_XFER_AUTOINC_EN, inc=3'b010 for one cycle between load and ack.
